// File: rtl/adc_conversion_arbiter.sv
// rtl/adc_conversion_arbiter.sv - round-robin arbiter sharing one SAR ADC between requesters
module adc_conversion_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int SETTLE_CYCLES  = 4,
   parameter int START_PULSE    = 4,
   parameter int TIMEOUT_CYCLES = 4095
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [16*NUM_REQ-1:0] req_config_1,
   input  logic [16*NUM_REQ-1:0] req_config_2,
   output logic [NUM_REQ-1:0]    req_ready,
   output logic [NUM_REQ-1:0]    rsp_valid,
   output logic [15:0]           rsp_result,
   output logic                  rsp_timeout,
   output logic                  busy,
   output logic [15:0]           adc_config_1_out,
   output logic [15:0]           adc_config_2_out,
   output logic                  adc_start_conversion_out,
   input  logic                  adc_conversion_finished_in,
   input  logic [15:0]           adc_result_in
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int JW = IW + 1;

   typedef enum logic [2:0] {IDLE, SETUP, START, WAIT, RESP} state_t;

   state_t        state;
   logic [IW-1:0] rr_ptr;
   logic [IW-1:0] gnt_idx;
   logic [IW-1:0] pick_idx;
   logic          pick_found;
   logic [JW-1:0] scan_idx;
   logic [31:0]   cnt;
   logic          fin_sync_1;
   logic          fin_sync_2;
   logic          fin_sync_3;
   logic          fin_rise;

   // Rotating-priority search: first pending requester at or after rr_ptr
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      scan_idx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         scan_idx = {1'b0, rr_ptr} + JW'(i);
         if (scan_idx >= JW'(NUM_REQ)) begin
            scan_idx = scan_idx - JW'(NUM_REQ);
         end
         if (!pick_found && req_valid[scan_idx[IW-1:0]]) begin
            pick_found = 1'b1;
            pick_idx   = scan_idx[IW-1:0];
         end
      end
   end

   // Accept pulse only while idle; forced low during reset so every output reads zero
   always_comb begin
      req_ready = '0;
      if (!rst && state == IDLE && pick_found) begin
         req_ready[pick_idx] = 1'b1;
      end
   end

   // Two-flop synchronizer plus registered rising-edge detect, running in every state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fin_sync_1 <= 1'b0;
         fin_sync_2 <= 1'b0;
         fin_sync_3 <= 1'b0;
         fin_rise   <= 1'b0;
      end else begin
         fin_sync_1 <= adc_conversion_finished_in;
         fin_sync_2 <= fin_sync_1;
         fin_sync_3 <= fin_sync_2;
         fin_rise   <= fin_sync_2 & ~fin_sync_3;
      end
   end

   // Conversion sequencer: grant, settle config, pulse start, wait for result or timeout, respond
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state                    <= IDLE;
         rr_ptr                   <= '0;
         gnt_idx                  <= '0;
         cnt                      <= '0;
         rsp_valid                <= '0;
         rsp_result               <= '0;
         rsp_timeout              <= 1'b0;
         busy                     <= 1'b0;
         adc_config_1_out         <= '0;
         adc_config_2_out         <= '0;
         adc_start_conversion_out <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_found) begin
                  gnt_idx          <= pick_idx;
                  adc_config_1_out <= req_config_1[{pick_idx, 4'b0000} +: 16];
                  adc_config_2_out <= req_config_2[{pick_idx, 4'b0000} +: 16];
                  if (pick_idx == IW'(NUM_REQ - 1)) begin
                     rr_ptr <= '0;
                  end else begin
                     rr_ptr <= pick_idx + 1'b1;
                  end
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= SETUP;
               end
            end
            SETUP: begin
               if (cnt == 32'(SETTLE_CYCLES - 1)) begin
                  cnt                      <= '0;
                  adc_start_conversion_out <= 1'b1;
                  state                    <= START;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            START: begin
               if (cnt == 32'(START_PULSE - 1)) begin
                  cnt                      <= '0;
                  adc_start_conversion_out <= 1'b0;
                  state                    <= WAIT;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            WAIT: begin
               // A real finish edge takes precedence over a coincident timeout
               if (fin_rise) begin
                  rsp_result  <= adc_result_in;
                  rsp_timeout <= 1'b0;
                  rsp_valid   <= NUM_REQ'(1) << gnt_idx;
                  state       <= RESP;
               end else if (cnt == 32'(TIMEOUT_CYCLES)) begin
                  rsp_result  <= '0;
                  rsp_timeout <= 1'b1;
                  rsp_valid   <= NUM_REQ'(1) << gnt_idx;
                  state       <= RESP;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            RESP: begin
               rsp_valid   <= '0;
               rsp_timeout <= 1'b0;
               busy        <= 1'b0;
               state       <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adc_conversion_arbiter.sv
// tb/tb_adc_conversion_arbiter.sv - randomized self-checking bench for adc_conversion_arbiter
module tb_adc_conversion_arbiter;

   localparam int S = 4;
   localparam int P = 4;

   logic        clk;
   logic        rst_a;
   logic        rst_b;
   logic        sel;
   logic [3:0]  req_valid;
   logic [15:0] cfg1 [4];
   logic [15:0] cfg2 [4];
   logic [63:0] req_config_1;
   logic [63:0] req_config_2;
   logic        fin;
   logic [15:0] adc_result;

   logic [3:0]  ready_a, rvalid_a, ready_b, rvalid_b;
   logic [15:0] result_a, result_b, c1_a, c1_b, c2_a, c2_b;
   logic        tmo_a, tmo_b, busy_a, busy_b, start_a, start_b;

   logic [3:0]  o_ready, o_rvalid;
   logic [15:0] o_result, o_c1, o_c2;
   logic        o_tmo, o_busy, o_start;

   int checks;
   int errors;
   int rr_m;

   assign req_config_1 = {cfg1[3], cfg1[2], cfg1[1], cfg1[0]};
   assign req_config_2 = {cfg2[3], cfg2[2], cfg2[1], cfg2[0]};

   assign o_ready  = sel ? ready_b  : ready_a;
   assign o_rvalid = sel ? rvalid_b : rvalid_a;
   assign o_result = sel ? result_b : result_a;
   assign o_tmo    = sel ? tmo_b    : tmo_a;
   assign o_busy   = sel ? busy_b   : busy_a;
   assign o_c1     = sel ? c1_b     : c1_a;
   assign o_c2     = sel ? c2_b     : c2_a;
   assign o_start  = sel ? start_b  : start_a;

   adc_conversion_arbiter dut_a (
      .clk                        (clk),
      .rst                        (rst_a),
      .req_valid                  (req_valid),
      .req_config_1               (req_config_1),
      .req_config_2               (req_config_2),
      .req_ready                  (ready_a),
      .rsp_valid                  (rvalid_a),
      .rsp_result                 (result_a),
      .rsp_timeout                (tmo_a),
      .busy                       (busy_a),
      .adc_config_1_out           (c1_a),
      .adc_config_2_out           (c2_a),
      .adc_start_conversion_out   (start_a),
      .adc_conversion_finished_in (fin),
      .adc_result_in              (adc_result)
   );

   adc_conversion_arbiter #(.TIMEOUT_CYCLES(16)) dut_b (
      .clk                        (clk),
      .rst                        (rst_b),
      .req_valid                  (req_valid),
      .req_config_1               (req_config_1),
      .req_config_2               (req_config_2),
      .req_ready                  (ready_b),
      .rsp_valid                  (rvalid_b),
      .rsp_result                 (result_b),
      .rsp_timeout                (tmo_b),
      .busy                       (busy_b),
      .adc_config_1_out           (c1_b),
      .adc_config_2_out           (c2_b),
      .adc_start_conversion_out   (start_b),
      .adc_conversion_finished_in (fin),
      .adc_result_in              (adc_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ready"},   32'(o_ready),  32'h0);
      check({tag, "_rvalid"},  32'(o_rvalid), 32'h0);
      check({tag, "_result"},  32'(o_result), 32'h0);
      check({tag, "_timeout"}, 32'(o_tmo),    32'h0);
      check({tag, "_busy"},    32'(o_busy),   32'h0);
      check({tag, "_cfg1"},    32'(o_c1),     32'h0);
      check({tag, "_cfg2"},    32'(o_c2),     32'h0);
      check({tag, "_start"},   32'(o_start),  32'h0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         #1;
         check("idle_rsp_valid", 32'(o_rvalid), 32'h0);
         check("idle_busy",      32'(o_busy),   32'h0);
      end
   endtask

   task automatic do_reset();
      #2;
      if (sel) rst_b = 1'b1; else rst_a = 1'b1;
      #1;
      check_all_zero("reset_pulse");
      @(negedge clk);
      if (sel) rst_b = 1'b0; else rst_a = 1'b0;
      rr_m = 0;
   endtask

   // One request/response transaction; the expected timeline comes from the grant rule
   // and the documented latencies, not from the sequencer's internal states.
   task automatic txn(input logic [3:0] mask, input logic [15:0] c1, input logic [15:0] c2,
                      input int fin_at, input int fin_low_at, input logic [15:0] res,
                      input int abort_at);
      int          g;
      int          tmo;
      int          resp_at;
      int          j;
      logic        to_exp;
      logic [15:0] res_exp;
      logic [3:0]  oh;
      tmo = sel ? 16 : 4095;
      g = -1;
      for (int i = 0; i < 4; i++) begin
         j = (rr_m + i) % 4;
         if (g < 0 && mask[2'(j)]) g = j;
      end
      if (g < 0) g = 0;
      rr_m    = (g + 1) % 4;
      oh      = 4'(1) << g;
      to_exp  = (fin_at < 0) || (fin_at + 3 > S + P + tmo + 1);
      resp_at = to_exp ? S + P + tmo + 2 : fin_at + 4;
      res_exp = to_exp ? 16'h0 : res;
      for (int k = 0; k < 4; k++) begin
         cfg1[k] = 16'($urandom);
         cfg2[k] = 16'($urandom);
      end
      cfg1[2'(g)] = c1;
      cfg2[2'(g)] = c2;
      req_valid   = mask;
      adc_result  = res;
      for (int c = 0; c <= resp_at + 1; c++) begin
         if (c > 0) @(negedge clk);
         if (c == 1) req_valid[2'(g)] = 1'b0;
         if (c == fin_low_at) fin = 1'b0;
         if (c == fin_at) fin = 1'b1;
         #1;
         if (c == abort_at) begin
            #2;
            if (sel) rst_b = 1'b1; else rst_a = 1'b1;
            #1;
            check_all_zero("abort");
            @(negedge clk);
            if (sel) rst_b = 1'b0; else rst_a = 1'b0;
            rr_m = 0;
            return;
         end
         if (c == 0) begin
            check("grant_ready", 32'(o_ready), 32'(oh));
            check("grant_busy",  32'(o_busy),  32'h0);
         end else if (c <= resp_at) begin
            check("ready_quiet", 32'(o_ready), 32'h0);
            check("busy_active", 32'(o_busy),  32'h1);
            check("cfg1_out",    32'(o_c1),    32'(c1));
            check("cfg2_out",    32'(o_c2),    32'(c2));
         end else begin
            check("busy_done",   32'(o_busy),  32'h0);
            check("cfg1_hold",   32'(o_c1),    32'(c1));
         end
         check("start_pulse", 32'(o_start), 32'(c >= S + 1 && c <= S + P));
         check("rsp_valid",   32'(o_rvalid), (c == resp_at) ? 32'(oh) : 32'h0);
         if (c == resp_at) begin
            check("rsp_timeout", 32'(o_tmo),    32'(to_exp));
            check("rsp_result",  32'(o_result), 32'(res_exp));
         end
         if (c == resp_at + 1) check("rsp_result_hold", 32'(o_result), 32'(res_exp));
      end
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      rr_m       = 0;
      sel        = 1'b0;
      rst_a      = 1'b1;
      rst_b      = 1'b1;
      req_valid  = 4'hF;
      fin        = 1'b0;
      adc_result = 16'h0;
      for (int k = 0; k < 4; k++) begin
         cfg1[k] = 16'hA5A5;
         cfg2[k] = 16'h5A5A;
      end
      repeat (2) @(negedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      rst_a     = 1'b0;
      req_valid = 4'h0;
      idle(2);

      // single request, finished 20 cycles after start rises
      txn(4'b0001, 16'hFC00, 16'h8421, S + 1 + 20, 0, 16'h0ABC, -1);
      idle(1);
      do_reset();

      // round robin with 1011 held pending
      repeat (4) txn(4'b1011, 16'($urandom), 16'($urandom), int'($urandom_range(9, 40)), 0,
                     16'($urandom), -1);
      req_valid = 4'h0;
      idle(2);

      // stale finished level carried into the next WAIT
      txn(4'b0100, 16'h1357, 16'h2468, 10, 0, 16'h1234, -1);
      txn(4'b1000, 16'h9BDF, 16'hACE0, 20, 12, 16'h5678, -1);

      // randomized back-to-back traffic
      for (int n = 0; n < 20; n++) begin
         txn(4'($urandom_range(1, 15)), 16'($urandom), 16'($urandom),
             int'($urandom_range(S + P + 1, 40)), 0, 16'($urandom), -1);
      end
      req_valid = 4'h0;
      idle(2);

      // reset during WAIT, then lowest pending index wins
      txn(4'b0010, 16'h7777, 16'h8888, -1, 0, 16'hDEAD, 15);
      req_valid = 4'h0;
      fin       = 1'b0;
      idle(30);
      txn(4'b0110, 16'h4321, 16'h8765, 20, 0, 16'hBEEF, -1);
      req_valid = 4'h0;
      idle(2);

      // short-timeout instance
      #2;
      rst_a = 1'b1;
      @(negedge clk);
      sel   = 1'b1;
      rst_b = 1'b0;
      rr_m  = 0;
      idle(2);
      txn(4'b0100, 16'h0F0F, 16'hF0F0, -1, 0, 16'h1111, -1);
      txn(4'b0001, 16'h3C3C, 16'hC3C3, 22, 0, 16'h2222, -1);
      txn(4'b0001, 16'h6666, 16'h9999, 21, 0, 16'h3333, -1);
      txn(4'b0001, 16'h1248, 16'h8421, 23, 0, 16'h4444, -1);
      req_valid = 4'h0;
      idle(3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/adc_conversion_arbiter.md
# adc_conversion_arbiter

Shares the single SAR ADC (`adc_top`) between `NUM_REQ` digital requesters. Each requester submits its own config words, and the block grants requests round-robin. For each granted request it drives the ADC config and start inputs, waits for the ADC's `conversion_finished`, and returns the 16-bit result to that requester. It sits between the user-side logic and `adc_top`, in the `clk` domain.

## Interface

**Parameters**
- `NUM_REQ`, 4: number of requesters (2..8).
- `SETTLE_CYCLES`, 4: cycles config is held stable before start (≥1).
- `START_PULSE`, 4: cycles `adc_start_conversion_out` stays high (≥1).
- `TIMEOUT_CYCLES`, 4095: maximum WAIT cycles before abort (≥4).

**Ports**
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in NUM_REQ: request pending, one bit per requester. Must be held until accepted.
- `req_config_1` in 16*NUM_REQ: slice i is requester i's `config_1`.
- `req_config_2` in 16*NUM_REQ: slice i is requester i's `config_2`.
- `req_ready` out NUM_REQ: one-hot accept pulse, combinational.
- `rsp_valid` out NUM_REQ: one-hot, one-cycle response pulse.
- `rsp_result` out 16: result; valid while any `rsp_valid` is high.
- `rsp_timeout` out 1: qualifies `rsp_valid`; the conversion timed out.
- `busy` out 1: state is not IDLE.
- `adc_config_1_out` out 16: to `adc_top` `config_1_in`.
- `adc_config_2_out` out 16: to `adc_top` `config_2_in`.
- `adc_start_conversion_out` out 1: to `adc_top` `start_conversion_in`.
- `adc_conversion_finished_in` in 1: from `adc_top`; asynchronous to `clk`.
- `adc_result_in` in 16: from `adc_top` `result_out`; stable while finished is high.

## Operation

**Synchronizer**
- `adc_conversion_finished_in` passes through a 2-flop synchronizer, then a registered rising-edge detect (`fin_rise`).
- The edge detector runs in every state. A finished level that is already high when entering WAIT produces no event.

**FSM states:** IDLE, SETUP, START, WAIT, RESP.

- **IDLE**
  - If any `req_valid` is set: pick the first set bit searching from `rr_ptr` upward, modulo `NUM_REQ`.
  - Assert `req_ready[g]` that cycle.
  - On the clock edge: capture `g` and both config slices into registers, set `rr_ptr` = (g+1) mod `NUM_REQ`, go to SETUP.
- **SETUP**
  - Captured configs drive `adc_config_*_out`.
  - Counter runs `SETTLE_CYCLES` cycles, then go to START.
- **START**
  - `adc_start_conversion_out` = 1 for exactly `START_PULSE` cycles, then go to WAIT with the timeout counter cleared.
- **WAIT**
  - On `fin_rise`: register `adc_result_in` into `rsp_result`, clear the timeout flag, go to RESP.
  - Otherwise, when the counter reaches `TIMEOUT_CYCLES`: `rsp_result` = 0, timeout flag = 1, go to RESP.
  - If `fin_rise` and the timeout coincide, `fin_rise` wins.
- **RESP**
  - `rsp_valid[g]` = 1 for one cycle, `rsp_timeout` = flag, then go to IDLE.
  - There is no response backpressure.

**Output and register behaviour**
- `adc_config_*_out` hold the last captured values in every state, including IDLE. Their reset value is 0.
- `rsp_result` holds its value until the next capture.
- A requester may deassert `req_valid` only after its `req_ready`.
- Requests arriving while `busy` wait; the arbiter grants none outside IDLE.

**Reset (asynchronous, any state)**
- State → IDLE, `rr_ptr` = 0, all counters cleared, synchronizer flops = 0.
- All outputs = 0.
- An in-flight conversion is dropped and no response is issued.

## Timing

- Request accepted at edge E0 (`req_ready` high during cycle 0).
- SETUP occupies cycles 1..`SETTLE_CYCLES`.
- START occupies the next `START_PULSE` cycles.
- WAIT ends on the cycle `fin_rise` is seen. That is 3 `clk` edges after the ADC finished edge: 2 synchronizer flops plus 1 edge register.
- RESP occupies one cycle.
- Minimum IDLE-to-IDLE time = 1 + `SETTLE_CYCLES` + `START_PULSE` + WAIT + 1.
- Back-to-back: with `req_valid` still pending, the next grant happens in the first IDLE cycle after RESP. There are no dead cycles beyond that one IDLE cycle.
- Timeout response appears exactly `SETTLE_CYCLES` + `START_PULSE` + `TIMEOUT_CYCLES` + 2 cycles after E0.

## Test plan

1. **Single request, normal completion.** Defaults. Req 0 with config_1 = 16'hFC00, config_2 = 16'h8421. ADC model raises finished 20 cycles after start, result = 16'h0ABC.
   - `adc_config_*_out` match from cycle 1.
   - Start is high for 4 cycles.
   - `rsp_valid` = 4'b0001 with `rsp_result` = 16'h0ABC and `rsp_timeout` = 0, 3 cycles after finished rises plus 1.
2. **Round-robin.** Hold `req_valid` = 4'b1011 from reset.
   - Grant order is 0, 1, 3, 0.
   - Each `req_ready` is one cycle; each `rsp_valid` routes to the matching bit.
3. **Timeout.** `TIMEOUT_CYCLES` = 16, ADC never finishes.
   - `rsp_valid[g]` = 1, `rsp_timeout` = 1, `rsp_result` = 0 at E0 + 4 + 4 + 16 + 2.
   - FSM returns to IDLE.
4. **Stale finished.** Finished held high from the previous conversion and into WAIT, then falls and rises again.
   - Only the second rise produces a response.
5. **Reset mid-WAIT.** Assert `rst` asynchronously during WAIT.
   - All outputs are 0 immediately.
   - No `rsp_valid` appears after release.
   - First grant after release goes to the lowest pending index (`rr_ptr` = 0).
6. **Simultaneous finish and timeout.** `fin_rise` arrives on the cycle the counter reaches `TIMEOUT_CYCLES`.
   - `rsp_timeout` = 0, `rsp_result` = ADC value.
